fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register. It drives the instruction memory read port and holds the PC. It delivers a registered {instruction, PC, PC+4, valid} bundle to the decoder, which contains the immediate generator. It handles decode back-pressure (stall) with a one-entry hold buffer, and handles redirects (branch/jump/trap) from downstream by flushing.

Parameters:
RESET_ADDR, 32'h0000_0000, PC of the first fetch after reset; must be word-aligned.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  synchronous active-low reset
o_imem_ren  output  1  instruction memory read enable
o_imem_raddr  output  32  word-aligned fetch address, combinational
i_imem_rdata  input  32  read data, valid exactly one cycle after a cycle with o_imem_ren=1
i_stall  input  1  decode cannot accept; hold IF/ID contents
i_redirect  input  1  flush and restart fetch at i_redirect_target
i_redirect_target  input  32  new PC
o_valid  output  1  IF/ID bundle holds a real instruction
o_inst  output  32  instruction word to decoder
o_pc  output  32  PC of o_inst
o_pc_plus4  output  32  o_pc + 4, mod 2^32
o_trap  output  1  misaligned-fetch flag (see Optional Feature)

Behaviour:
- Reset (i_rst_n=0 at edge):
  - pc <= RESET_ADDR; state <= IDLE.
  - o_valid=0, o_inst=32'h0000_0013 (NOP), o_pc=0, o_pc_plus4=4, o_trap=0.
  - In-flight flag and buffer are cleared; a response arriving after reset is ignored.
- States:
  - IDLE: first cycle after reset. ren=1, raddr=pc, pc<=pc+4 → FETCH.
  - FETCH: a response is in flight each cycle. Without stall, IF/ID <= {rdata, req_pc}, o_valid<=1, and a new request issues the same cycle (throughput 1/cycle).
  - HOLD: stalled. ren=0, pc frozen. The response in flight at stall entry is captured into the buffer (buf_valid<=1). When i_stall drops: IF/ID <= buffer, buf_valid<=0, request at pc issued that cycle → FETCH.
- Latency: request in cycle n → visible on o_inst after the edge ending cycle n+1.
- Stall rules:
  - i_stall with o_valid=1 holds o_* unchanged.
  - i_stall with o_valid=0 is ignored; the bubble may be overwritten.
  - At most one buffered response; ren=0 throughout HOLD guarantees no overflow.
- Redirect:
  - raddr = i_redirect ? {target[31:2],2'b00} : pc, combinational; ren=1 that cycle.
  - Edge: o_valid<=0, buf_valid<=0, in-flight response from the previous cycle discarded, pc<=target+4, state → FETCH.
  - Redirect has priority over stall.
  - Redirect on consecutive cycles: the last one wins.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC → 0.
- Simultaneous stall deassert + redirect: redirect wins; buffer dropped.
- Reset mid-HOLD or mid-redirect: all of the above is discarded; restart from IDLE.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - A redirect with target[1:0]!=0 issues no request (ren=0).
  - Next edge: o_valid<=1, o_inst<=NOP, o_pc<=target, o_trap<=1.
  - Fetch then idles with ren=0 until the next redirect, which clears o_trap.
- Undefined: o_trap tied 0; target[1:0] ignored (forced to 00).

Decomposition:
- Package fetch_pkg:
  - NOP_INST = 32'h0000_0013
  - DEFAULT_RESET_ADDR
  - state encoding IDLE/FETCH/HOLD
  - IF/ID bundle field widths
- Sub-module fetch_hold_buf: 1-entry {inst, pc} buffer with capture/release/clear; holds all stall-buffer state.

Test Plan:
1. Reset release, RESET_ADDR=0x100, memory returns addr-derived data → raddr 0x100, 0x104, 0x108 on consecutive cycles; o_valid rises 2 cycles after reset release; o_pc=0x100, o_pc_plus4=0x104.
2. i_stall high 3 cycles while o_pc=0x104 → o_* frozen, ren=0; after release o_pc=0x108 (from buffer), then 0x10C; no instruction lost or duplicated.
3. i_redirect with target 0x200 while fetching 0x10C → raddr=0x200 that cycle, o_valid=0 next cycle, then o_pc=0x200, 0x204; 0x110 never appears.
4. Redirect 0x300 asserted during HOLD with stall still high → buffer dropped, o_valid=0, then o_pc=0x300.
5. PC=0xFFFF_FFF8, free-running → o_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; o_pc_plus4 for 0xFFFF_FFFC = 0.
6. With FETCH_MISALIGN_CHECK_EN, redirect 0x402 → o_trap=1, o_pc=0x402, o_inst=NOP, ren=0 until a redirect to 0x500 resumes fetch with o_trap=0. Without the macro: fetch at 0x400, o_trap=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   - XLEN / ILEN        : address and instruction widths
//   - NOP_INST           : canonical NOP (addi x0, x0, 0) shown while IF/ID is empty
//   - DEFAULT_RESET_ADDR : default first fetch address
//   - fetch_state_e      : fetch FSM encoding (IDLE / FETCH / HOLD)
//   - ifid_t             : IF/ID pipeline register bundle
//   - hold_entry_t       : payload of the one-entry stall buffer
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INST           = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP            = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            trap;
  } ifid_t;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } hold_entry_t;

  localparam ifid_t IFID_RESET = '{
    valid:    1'b0,
    inst:     NOP_INST,
    pc:       '0,
    pc_plus4: PC_STEP,
    trap:     1'b0
  };

  // Clears the two low address bits; written as a mask so every input bit
  // participates in the expression.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf
// One-entry {inst, pc} buffer that catches the instruction-memory response
// still in flight when decode stalls.
// Ports:
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_capture          : store {i_inst, i_pc}, mark entry valid
//   i_release          : entry consumed by IF/ID, mark empty
//   i_clear            : drop entry (redirect); wins over capture
//   i_inst, i_pc       : response payload to capture
//   o_valid            : entry holds a response
//   o_inst, o_pc       : stored payload
// -----------------------------------------------------------------------------
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_capture,
  input  logic            i_release,
  input  logic            i_clear,
  input  logic [ILEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [ILEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
);

  logic        valid_q;
  hold_entry_t entry_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
    end else if (i_clear || i_release) begin
      valid_q <= 1'b0;
    end else if (i_capture) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: the payload is deliberately left without reset; it is only ever
  // observed when valid_q is set, so resetting it would just add wiring.
  always_ff @(posedge i_clk) begin
    if (i_capture && !i_clear) begin
      entry_q <= '{inst: i_inst, pc: i_pc};
    end
  end

  assign o_valid = valid_q;
  assign o_inst  = entry_q.inst;
  assign o_pc    = entry_q.pc;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch plus IF/ID pipeline register. Issues one word-aligned read
// per cycle, delivers {inst, pc, pc+4, valid} to decode one cycle after the
// response, absorbs decode stalls with a one-entry hold buffer and restarts on
// downstream redirects.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target issues no read and
//               presents a NOP with o_trap=1 at that target; fetch stays idle
//               until the next redirect.
//   undefined : o_trap is always 0 and target[1:0] is ignored.
//
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   o_imem_ren            : instruction memory read enable
//   o_imem_raddr          : word-aligned fetch address (combinational)
//   i_imem_rdata          : read data, valid the cycle after o_imem_ren
//   i_stall               : decode cannot accept; hold IF/ID
//   i_redirect            : flush and restart at i_redirect_target
//   i_redirect_target     : new PC
//   o_valid, o_inst, o_pc, o_pc_plus4, o_trap : IF/ID bundle
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_ren,
  output logic [XLEN-1:0] o_imem_raddr,
  input  logic [ILEN-1:0] i_imem_rdata,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_target,
  output logic            o_valid,
  output logic [ILEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_trap
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;        // address of the next sequential request
  logic [XLEN-1:0] req_pc_q;    // address of the request now in flight
  logic            inflight_q;  // a response arrives on i_imem_rdata this cycle
  ifid_t           ifid_q;

  logic            halted_q;     // parked after a misaligned redirect
  logic            bad_redirect; // redirect to a misaligned target (feature only)
  logic            stall_eff;    // stall only matters when IF/ID holds something

  logic            buf_capture;
  logic            buf_release;
  logic            buf_valid;
  logic [ILEN-1:0] buf_inst;
  logic [XLEN-1:0] buf_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_redirect = i_redirect && (i_redirect_target[1:0] != 2'b00);
`else
  assign bad_redirect = 1'b0;
`endif

  assign stall_eff = i_stall && ifid_q.valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Redirect overrides everything, including a pending stall.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (i_redirect) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (stall_eff && !halted_q) state_d = HOLD;
        HOLD:    if (!i_stall) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The request is dropped in the stall-entry cycle so only the
  // response already in flight needs buffering.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_imem_ren   = 1'b0;
    o_imem_raddr = word_align(pc_q);
    if (i_redirect) begin
      o_imem_raddr = word_align(i_redirect_target);
      o_imem_ren   = !bad_redirect;
    end else begin
      unique case (state_q)
        IDLE:    o_imem_ren = 1'b1;
        FETCH:   o_imem_ren = !halted_q && !stall_eff;
        HOLD:    o_imem_ren = !i_stall;
        default: o_imem_ren = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Hold buffer
  // ---------------------------------------------------------------------------
  assign buf_capture = (state_q == FETCH) && !i_redirect && !halted_q &&
                       stall_eff && inflight_q;
  assign buf_release = (state_q == HOLD) && !i_redirect && !i_stall;

  fetch_hold_buf u_hold_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_capture (buf_capture),
    .i_release (buf_release),
    .i_clear   (i_redirect),
    .i_inst    (i_imem_rdata),
    .i_pc      (req_pc_q),
    .o_valid   (buf_valid),
    .o_inst    (buf_inst),
    .o_pc      (buf_pc)
  );

  // ---------------------------------------------------------------------------
  // PC and in-flight tracking. Every issued request advances pc to the issued
  // address + 4, which covers sequential fetch, redirect and hold release
  // alike. A redirect replaces the in-flight tag, so the stale response that
  // arrives during the redirect cycle is never consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q       <= RESET_ADDR;
      req_pc_q   <= RESET_ADDR;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= o_imem_ren;
      if (o_imem_ren) begin
        pc_q     <= o_imem_raddr + PC_STEP;
        req_pc_q <= o_imem_raddr;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      halted_q <= 1'b0;
    end else if (i_redirect) begin
      halted_q <= bad_redirect;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ifid_q <= IFID_RESET;
    end else if (i_redirect) begin
      if (bad_redirect) begin
        ifid_q <= '{valid:    1'b1,
                    inst:     NOP_INST,
                    pc:       i_redirect_target,
                    pc_plus4: i_redirect_target + PC_STEP,
                    trap:     1'b1};
      end else begin
        ifid_q.valid <= 1'b0;
        ifid_q.trap  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!halted_q && !stall_eff) begin
            if (inflight_q) begin
              ifid_q <= '{valid:    1'b1,
                          inst:     i_imem_rdata,
                          pc:       req_pc_q,
                          pc_plus4: req_pc_q + PC_STEP,
                          trap:     1'b0};
            end else begin
              ifid_q.valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!i_stall) begin
            if (buf_valid) begin
              ifid_q <= '{valid:    1'b1,
                          inst:     buf_inst,
                          pc:       buf_pc,
                          pc_plus4: buf_pc + PC_STEP,
                          trap:     1'b0};
            end else begin
              ifid_q.valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid    = ifid_q.valid;
  assign o_inst     = ifid_q.inst;
  assign o_pc       = ifid_q.pc;
  assign o_pc_plus4 = ifid_q.pc_plus4;
  assign o_trap     = ifid_q.trap;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A small memory model returns an
// address-derived word one cycle after each read (and garbage otherwise).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN selects the expected
// behaviour of the misaligned-redirect vector.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'h0000_0100;
  localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_ADDR(RST_ADDR)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .o_imem_ren        (ren),
    .o_imem_raddr      (raddr),
    .i_imem_rdata      (rdata),
    .i_stall           (stall),
    .i_redirect        (redirect),
    .i_redirect_target (target),
    .o_valid           (valid),
    .o_inst            (inst),
    .o_pc              (pc),
    .o_pc_plus4        (pc_plus4),
    .o_trap            (trap)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: data for a request appears the following cycle only.
  always @(posedge clk) begin
    rdata <= ren ? mem_word(raddr) : GARBAGE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let combinational logic settle.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    stall    = s;
    redirect = r;
    target   = t;
    #1;
  endtask

  task automatic check_req(input string tag, input logic exp_ren, input logic [31:0] exp_addr);
    check({tag, ".ren"}, 32'(ren), 32'(exp_ren));
    if (exp_ren) check({tag, ".raddr"}, raddr, exp_addr);
  endtask

  task automatic check_out(input string tag, input logic exp_valid, input logic [31:0] exp_pc,
                           input logic [31:0] exp_inst, input logic exp_trap);
    check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    check({tag, ".trap"}, 32'(trap), 32'(exp_trap));
    if (exp_valid) begin
      check({tag, ".pc"}, pc, exp_pc);
      check({tag, ".inst"}, inst, exp_inst);
      check({tag, ".pc_plus4"}, pc_plus4, exp_pc + 32'd4);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'd0);
    check({tag, ".inst"}, inst, NOP_INST);
    check({tag, ".pc"}, pc, 32'h0);
    check({tag, ".pc_plus4"}, pc_plus4, 32'h4);
    check({tag, ".trap"}, 32'(trap), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    target   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("rst_hold");

    // 1: reset release, back-to-back requests, 2-cycle latency
    @(negedge clk); rst_n = 1'b1; #1;
    check_reset_state("t1_c0");
    check_req("t1_c0", 1'b1, 32'h100);
    step(0, 0, 0); check_req("t1_c1", 1'b1, 32'h104); check_out("t1_c1", 0, 0, 0, 0);
    step(0, 0, 0); check_req("t1_c2", 1'b1, 32'h108);
    check_out("t1_c2", 1, 32'h100, mem_word(32'h100), 0);

    // 2: three-cycle stall at 0x104, buffered 0x108 replayed, then 0x10C
    step(1, 0, 0); check_req("t2_s0", 1'b0, 0); check_out("t2_s0", 1, 32'h104, mem_word(32'h104), 0);
    step(1, 0, 0); check_req("t2_s1", 1'b0, 0); check_out("t2_s1", 1, 32'h104, mem_word(32'h104), 0);
    step(1, 0, 0); check_req("t2_s2", 1'b0, 0); check_out("t2_s2", 1, 32'h104, mem_word(32'h104), 0);
    step(0, 0, 0); check_req("t2_rel", 1'b1, 32'h10C); check_out("t2_rel", 1, 32'h104, mem_word(32'h104), 0);
    step(0, 0, 0); check_req("t2_buf", 1'b1, 32'h110); check_out("t2_buf", 1, 32'h108, mem_word(32'h108), 0);

    // 3: redirect to 0x200 while showing 0x10C; stall during the bubble is ignored
    step(0, 1, 32'h200); check_req("t3_r", 1'b1, 32'h200); check_out("t3_r", 1, 32'h10C, mem_word(32'h10C), 0);
    step(1, 0, 0); check_req("t3_b", 1'b1, 32'h204); check_out("t3_b", 0, 0, 0, 0);
    step(0, 0, 0); check_req("t3_n0", 1'b1, 32'h208); check_out("t3_n0", 1, 32'h200, mem_word(32'h200), 0);

    // 4: redirect to 0x300 during HOLD with stall still high drops the buffer
    step(1, 0, 0); check_req("t4_s", 1'b0, 0); check_out("t4_s", 1, 32'h204, mem_word(32'h204), 0);
    step(1, 1, 32'h300); check_req("t4_r", 1'b1, 32'h300); check_out("t4_r", 1, 32'h204, mem_word(32'h204), 0);
    step(0, 0, 0); check_req("t4_b", 1'b1, 32'h304); check_out("t4_b", 0, 0, 0, 0);
    step(0, 0, 0); check_out("t4_n0", 1, 32'h300, mem_word(32'h300), 0);

    // 5: PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFF8); check_req("t5_r", 1'b1, 32'hFFFF_FFF8);
    step(0, 0, 0); check_req("t5_b", 1'b1, 32'hFFFF_FFFC); check_out("t5_b", 0, 0, 0, 0);
    step(0, 0, 0); check_req("t5_n0", 1'b1, 32'h0); check_out("t5_n0", 1, 32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8), 0);
    step(0, 0, 0); check_out("t5_n1", 1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 0);
    check("t5_wrap_plus4", pc_plus4, 32'h0);
    step(0, 0, 0); check_out("t5_n2", 1, 32'h0, mem_word(32'h0), 0);

    // 6: misaligned redirect
`ifdef FETCH_MISALIGN_CHECK_EN
    step(0, 1, 32'h402); check_req("t6_r", 1'b0, 0);
    step(0, 0, 0); check_req("t6_t0", 1'b0, 0); check_out("t6_t0", 1, 32'h402, NOP_INST, 1);
    step(0, 0, 0); check_req("t6_t1", 1'b0, 0); check_out("t6_t1", 1, 32'h402, NOP_INST, 1);
    step(0, 1, 32'h500); check_req("t6_r2", 1'b1, 32'h500);
    step(0, 0, 0); check_out("t6_b", 0, 0, 0, 0);
    step(0, 0, 0); check_out("t6_n0", 1, 32'h500, mem_word(32'h500), 0);
`else
    step(0, 1, 32'h402); check_req("t6_r", 1'b1, 32'h400);
    step(0, 0, 0); check_req("t6_b", 1'b1, 32'h404); check_out("t6_b", 0, 0, 0, 0);
    step(0, 0, 0); check_out("t6_n0", 1, 32'h400, mem_word(32'h400), 0);
`endif

    // 7: reset in the middle of HOLD restarts cleanly from RESET_ADDR
    step(1, 0, 0); check_req("t7_s", 1'b0, 0);
    step(1, 0, 0); rst_n = 1'b0;
    step(0, 0, 0); rst_n = 1'b1; #1;
    check_reset_state("t7_rst");
    check_req("t7_c0", 1'b1, 32'h100);
    step(0, 0, 0); check_req("t7_c1", 1'b1, 32'h104); check_out("t7_c1", 0, 0, 0, 0);
    step(0, 0, 0); check_out("t7_c2", 1, 32'h100, mem_word(32'h100), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
